uart_rcv_block: RTL and testbench

Serial receive engine for the UART peripheral. It sits directly upstream of `apb_slave`. It consumes `apb_slave`'s `bit_period` and `data_size` configuration outputs and its `data_read` acknowledge. It produces the `rx_data`, `data_ready`, `overrun_error` and `framing_error` status that `apb_slave` exposes on the bus. Framing is 1 start bit, 5–8 data bits sent LSB first, and 1 stop bit, with no parity.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_bit_timer.sv | 41 ++++
 rtl/uart_rcv_block.sv | 164 ++++++++++++++++
 tb/tb_uart_rcv_block.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    localparam int DATA_SIZE_W  = 4;
    localparam int BIT_PERIOD_W = 14;

    localparam logic [DATA_SIZE_W-1:0]  MIN_DATA_SIZE  = 4'd5;
    localparam logic [DATA_SIZE_W-1:0]  MAX_DATA_SIZE  = 4'd8;
    localparam logic [BIT_PERIOD_W-1:0] MIN_BIT_PERIOD = 14'd4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        LOAD
    } rcv_state_t;

    // Out-of-range sizes fall back to a full byte.
    function automatic logic [DATA_SIZE_W-1:0] eff_size(input logic [DATA_SIZE_W-1:0] ds);
        return ((ds >= MIN_DATA_SIZE) && (ds <= MAX_DATA_SIZE)) ? ds : MAX_DATA_SIZE;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter: one-cycle tick each time the loaded count elapses,
// then reloads with the full period. Idles at zero after clear.
module uart_bit_timer
    import uart_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    load_half,
    input  logic [BIT_PERIOD_W-1:0] period,
    output logic                    tick
);

    logic [BIT_PERIOD_W-1:0] count_q, count_d;

    assign tick = (count_q == BIT_PERIOD_W'(1));

    // Next count: clear, half-period load, reload on tick, else count down.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (load_half) begin
            count_d = period >> 1;
        end else if (tick) begin
            count_d = period;
        end else if (count_q != '0) begin
            count_d = count_q - BIT_PERIOD_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_rcv_block.sv
// UART serial receive engine: synchronizer, frame FSM, shift register and
// receive status flags feeding the APB register block.
module uart_rcv_block
    import uart_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    serial_in,
    input  logic [BIT_PERIOD_W-1:0] bit_period,
    input  logic [DATA_SIZE_W-1:0]  data_size,
    input  logic                    data_read,
    output logic [7:0]              rx_data,
    output logic                    data_ready,
    output logic                    overrun_error,
    output logic                    framing_error
);

    logic                    sync1_q, sync2_q;
    rcv_state_t              state_q, state_d;
    logic [BIT_PERIOD_W-1:0] bp_q, bp_d;
    logic [DATA_SIZE_W-1:0]  size_q, size_d;
    logic [DATA_SIZE_W-1:0]  idx_q, idx_d;
    logic [7:0]              shift_q, shift_d;
    logic [7:0]              rx_q, rx_d;
    logic                    dr_q, dr_d;
    logic                    ov_q, ov_d;
    logic                    fe_q, fe_d;
    logic                    tmr_clear, tmr_load_half, tmr_tick;
    logic                    start_edge;

    // sync1 holds the value sync2 takes next edge, so this flags the synced
    // line falling on the coming edge; the FSM enters START on that edge.
    assign start_edge = sync2_q && !sync1_q;

    uart_bit_timer u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (tmr_clear),
        .load_half (tmr_load_half),
        .period    (bp_d),
        .tick      (tmr_tick)
    );

    // Two-flop synchronizer for the asynchronous RX line (idle high).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= serial_in;
            sync2_q <= sync1_q;
        end
    end

    // Frame FSM next-state, datapath and status flag updates.
    always_comb begin
        state_d       = state_q;
        bp_d          = bp_q;
        size_d        = size_q;
        idx_d         = idx_q;
        shift_d       = shift_q;
        rx_d          = rx_q;
        dr_d          = dr_q;
        ov_d          = ov_q;
        fe_d          = fe_q;
        tmr_clear     = 1'b0;
        tmr_load_half = 1'b0;

        if (data_read) begin
            dr_d = 1'b0;
            ov_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                tmr_clear = 1'b1;
                if (start_edge && (bit_period >= MIN_BIT_PERIOD)) begin
                    state_d       = START;
                    bp_d          = bit_period;
                    size_d        = eff_size(data_size);
                    idx_d         = '0;
                    tmr_clear     = 1'b0;
                    tmr_load_half = 1'b1;
                end
            end
            START: begin
                if (tmr_tick) begin
                    if (!sync2_q) begin
                        state_d = DATA;
                        fe_d    = 1'b0;
                    end else begin
                        state_d   = IDLE;
                        tmr_clear = 1'b1;
                    end
                end
            end
            DATA: begin
                if (tmr_tick) begin
                    shift_d = {sync2_q, shift_q[7:1]};
                    if (idx_q == (size_q - DATA_SIZE_W'(1))) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + DATA_SIZE_W'(1);
                    end
                end
            end
            STOP: begin
                if (tmr_tick) begin
                    tmr_clear = 1'b1;
                    if (sync2_q) begin
                        state_d = LOAD;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            LOAD: begin
                // Bits arrived MSB-side first; shift down to right-justify.
                rx_d = shift_q >> (MAX_DATA_SIZE - size_q);
                dr_d = 1'b1;
                if (dr_q && !data_read) begin
                    ov_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                tmr_clear = 1'b1;
            end
        endcase
    end

    // State, latched frame configuration and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            bp_q    <= '0;
            size_q  <= MAX_DATA_SIZE;
            idx_q   <= '0;
            shift_q <= '0;
            rx_q    <= '0;
            dr_q    <= 1'b0;
            ov_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            bp_q    <= bp_d;
            size_q  <= size_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            rx_q    <= rx_d;
            dr_q    <= dr_d;
            ov_q    <= ov_d;
            fe_q    <= fe_d;
        end
    end

    assign rx_data       = rx_q;
    assign data_ready    = dr_q;
    assign overrun_error = ov_q;
    assign framing_error = fe_q;

endmodule

// File: tb/tb_uart_rcv_block.sv
// Self-checking bench for uart_rcv_block: directed table, corner sequences
// and randomized frames against a frame-level status model.
module tb_uart_rcv_block;

    logic        clk = 1'b0;
    logic        rst;
    logic        serial_in;
    logic [13:0] bit_period;
    logic [3:0]  data_size;
    logic        data_read;
    logic [7:0]  rx_data;
    logic        data_ready;
    logic        overrun_error;
    logic        framing_error;

    uart_rcv_block dut (
        .clk           (clk),
        .rst           (rst),
        .serial_in     (serial_in),
        .bit_period    (bit_period),
        .data_size     (data_size),
        .data_read     (data_read),
        .rx_data       (rx_data),
        .data_ready    (data_ready),
        .overrun_error (overrun_error),
        .framing_error (framing_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rise_cyc = -1;
    logic prev_dr = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_ready && !prev_dr) rise_cyc = cyc;
        prev_dr = data_ready;
    end

    // Frame-level expected status.
    logic [7:0] m_rx;
    logic       m_dr, m_ov, m_fe;

    typedef struct {
        bit         rd;
        bit         send;
        int         bp;
        int         ds;
        logic [7:0] data;
        logic       stop;
        logic [7:0] e_rx;
        logic       e_dr;
        logic       e_ov;
        logic       e_fe;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] rx, input logic dr,
                           input logic ov, input logic fe);
        chk($sformatf("%s.rx_data", tag), rx_data, rx);
        chk($sformatf("%s.data_ready", tag), data_ready, dr);
        chk($sformatf("%s.overrun_error", tag), overrun_error, ov);
        chk($sformatf("%s.framing_error", tag), framing_error, fe);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int eff_n(input int ds);
        return (ds >= 5 && ds <= 8) ? ds : 8;
    endfunction

    task automatic pulse_read();
        data_read = 1'b1;
        tick();
        data_read = 1'b0;
        m_dr = 1'b0;
        m_ov = 1'b0;
    endtask

    // Drives one frame; invalid bit periods still toggle the line at 10 clocks/bit.
    task automatic send_frame(input int bp, input int ds, input logic [7:0] data,
                              input logic stop, input bit scramble);
        int line_bp;
        int n;
        line_bp = (bp >= 4) ? bp : 10;
        n       = (bp >= 4) ? eff_n(ds) : 8;
        bit_period = 14'(bp);
        data_size  = 4'(ds);
        serial_in  = 1'b0;
        repeat (line_bp) tick();
        if (scramble) begin
            bit_period = 14'($urandom_range(4, 40));
            data_size  = 4'($urandom_range(0, 15));
        end
        for (int k = 0; k < n; k++) begin
            serial_in = data[k];
            repeat (line_bp) tick();
        end
        serial_in = stop;
        repeat (line_bp) tick();
        serial_in = 1'b1;
        repeat (6) tick();
    endtask

    function automatic void model_frame(input int bp, input int ds, input logic [7:0] data,
                                        input logic stop);
        int n;
        if (bp < 4) return;
        n = eff_n(ds);
        if (stop) begin
            m_ov = m_ov | m_dr;
            m_dr = 1'b1;
            m_rx = 8'((int'(data)) % (1 << n));
            m_fe = 1'b0;
        end else begin
            m_fe = 1'b1;
        end
    endfunction

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c0;
        int d;
        int bp;
        int ds;
        logic [7:0] data;
        logic stop;
        bit scr;

        tbl[0]  = '{0, 1, 16, 5,  8'hED, 1'b1, 8'h0D, 1'b1, 1'b1, 1'b0};
        tbl[1]  = '{0, 1, 10, 8,  8'h3C, 1'b0, 8'h0D, 1'b1, 1'b1, 1'b1};
        tbl[2]  = '{0, 1, 10, 8,  8'h11, 1'b1, 8'h11, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{1, 1, 12, 8,  8'h55, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{0, 1, 12, 8,  8'hAA, 1'b1, 8'hAA, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{1, 0, 12, 8,  8'h00, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{0, 1, 9,  0,  8'h96, 1'b1, 8'h96, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{0, 1, 7,  6,  8'hFF, 1'b1, 8'h3F, 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{1, 1, 4,  12, 8'hC3, 1'b1, 8'hC3, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1, 1, 5,  7,  8'h80, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{0, 1, 3,  8,  8'h42, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{0, 1, 20, 8,  8'hE7, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        tbl[12] = '{0, 1, 11, 5,  8'hFF, 1'b1, 8'h1F, 1'b1, 1'b1, 1'b0};

        rst        = 1'b1;
        serial_in  = 1'b1;
        data_read  = 1'b0;
        bit_period = 14'd10;
        data_size  = 4'd8;
        repeat (3) tick();
        chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        m_rx = 8'h00; m_dr = 1'b0; m_ov = 1'b0; m_fe = 1'b0;

        // First frame with latency check: E = c0+2, ready visible by E+97.
        rise_cyc = -1;
        c0 = cyc;
        send_frame(10, 8, 8'hA5, 1'b1, 1'b0);
        model_frame(10, 8, 8'hA5, 1'b1);
        d = rise_cyc - c0;
        checks++;
        if (rise_cyc < 0 || d < 98 || d > 99) begin
            errors++;
            $display("FAIL a5.ready_cycle: rose %0d cycles after start, required 98..99", d);
        end
        chk_all("a5", m_rx, m_dr, m_ov, m_fe);

        for (int i = 0; i < 13; i++) begin
            if (tbl[i].rd) pulse_read();
            if (tbl[i].send) begin
                send_frame(tbl[i].bp, tbl[i].ds, tbl[i].data, tbl[i].stop, 1'b0);
                model_frame(tbl[i].bp, tbl[i].ds, tbl[i].data, tbl[i].stop);
            end
            chk_all($sformatf("tbl%0d", i), tbl[i].e_rx, tbl[i].e_dr, tbl[i].e_ov, tbl[i].e_fe);
        end

        // Short low glitch must be rejected at the start sample.
        bit_period = 14'd10;
        data_size  = 4'd8;
        tick();
        serial_in = 1'b0;
        repeat (3) tick();
        serial_in = 1'b1;
        repeat (30) tick();
        chk_all("glitch", m_rx, m_dr, m_ov, m_fe);

        // data_read landing in the LOAD cycle: byte replaced, no overrun.
        fork
            send_frame(10, 8, 8'h6B, 1'b1, 1'b0);
            begin
                repeat (97) tick();
                data_read = 1'b1;
                tick();
                data_read = 1'b0;
            end
        join
        m_rx = 8'h6B; m_dr = 1'b1; m_ov = 1'b0; m_fe = 1'b0;
        chk_all("read_at_load", m_rx, m_dr, m_ov, m_fe);

        // Reset during data bit 3; remaining line stays high so no new frame.
        fork
            send_frame(10, 8, 8'hF8, 1'b1, 1'b0);
            begin
                repeat (45) tick();
                #1 rst = 1'b1;
                #1 chk_all("rst_mid", 8'h00, 1'b0, 1'b0, 1'b0);
                tick();
                rst = 1'b0;
            end
        join
        m_rx = 8'h00; m_dr = 1'b0; m_ov = 1'b0; m_fe = 1'b0;
        chk_all("rst_after", m_rx, m_dr, m_ov, m_fe);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) pulse_read();
            bp   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(4, 24));
            ds   = int'($urandom_range(0, 15));
            data = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            scr  = (bp >= 4) && ($urandom_range(0, 1) == 1);
            send_frame(bp, ds, data, stop, scr);
            model_frame(bp, ds, data, stop);
            chk_all($sformatf("rand%0d", i), m_rx, m_dr, m_ov, m_fe);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
